// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: round-robin, burst-limited mover from four source FIFOs
// into one destination FIFO. The read strobe and the pushed word are registered.
//
// Ports:
//   clk                rising-edge clock
//   reset              asynchronous, active-low reset
//   fifo_empty[3:0]    per-source empty flag
//   fifo_almost_empty  per-source flag: the FIFO holds at most one word
//   fifo_error[3:0]    per-source error flag; latches the scheduler in ERROR
//   fifo_data          word of FIFO i at [i*DATA_SIZE +: DATA_SIZE], valid
//                      the cycle after that FIFO's pop
//   out_almost_full    destination almost full (stall)
//   out_pause          destination pause request (stall)
//   fifo_pop[3:0]      one-hot read strobe to the sources
//   out_push/out_data  write strobe and word to the destination, 2 cycles
//                      after the matching pop
//   grant_id           FIFO currently or most recently granted
//   idle               IDLE state and no popped word still travelling
//   sched_error        sticky error, cleared only by reset
module fifo_rr_scheduler #(
   parameter int DATA_SIZE = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             fifo_empty,
   input  logic [3:0]             fifo_almost_empty,
   input  logic [3:0]             fifo_error,
   input  logic [4*DATA_SIZE-1:0] fifo_data,
   input  logic                   out_almost_full,
   input  logic                   out_pause,
   output logic [3:0]             fifo_pop,
   output logic                   out_push,
   output logic [DATA_SIZE-1:0]   out_data,
   output logic [1:0]             grant_id,
   output logic                   idle,
   output logic                   sched_error
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BURST = 2'd1;
   localparam logic [1:0] S_ERROR = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [3:0]           pop_q, pop_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [1:0]           last_q, last_d;
   logic [1:0]           grant_q, grant_d;
   logic                 err_q, err_d;
   logic                 infl_vld_q;
   logic [1:0]           infl_id_q;
   logic                 push_q;
   logic [DATA_SIZE-1:0] data_q;

   logic       stall;
   logic [3:0] elig;
   logic       pick_vld;
   logic [1:0] pick_id;

   assign stall = out_almost_full | out_pause;

   // A FIFO popped this cycle with only one word left is already drained,
   // even though its empty flag has not caught up yet.
   assign elig = ~fifo_empty & ~(pop_q & fifo_almost_empty);

   // Search last+1, last+2, last+3, then last itself; lowest offset wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = last_q;
      for (int k = 4; k >= 1; k--) begin
         if (elig[last_q + 2'(k)]) begin
            pick_vld = 1'b1;
            pick_id  = last_q + 2'(k);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pop_d   = 4'b0000;
      cnt_d   = cnt_q;
      last_d  = last_q;
      grant_d = grant_q;
      err_d   = err_q;
      if (|fifo_error) begin
         state_d = S_ERROR;
         err_d   = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (!stall && pick_vld) begin
                  pop_d   = 4'b0001 << pick_id;
                  last_d  = pick_id;
                  grant_d = pick_id;
                  cnt_d   = 4'd1;
                  state_d = S_BURST;
               end
            end
            S_BURST: begin
               if (stall) begin
                  pop_d = 4'b0000;
               end else if (elig[grant_q] && (cnt_q < 4'(MAX_BURST))) begin
                  pop_d = 4'b0001 << grant_q;
                  cnt_d = cnt_q + 4'd1;
               end else if (pick_vld) begin
                  pop_d   = 4'b0001 << pick_id;
                  last_d  = pick_id;
                  grant_d = pick_id;
                  cnt_d   = 4'd1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_ERROR: begin
               state_d = S_ERROR;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pop_q   <= 4'b0000;
         cnt_q   <= 4'd0;
         last_q  <= 2'd3;
         grant_q <= 2'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pop_q   <= pop_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         err_q   <= err_d;
      end
   end

   // Pop cycle -> data cycle (capture) -> push cycle. grant_q names the
   // FIFO being popped whenever pop_q is non-zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         infl_vld_q <= 1'b0;
         infl_id_q  <= 2'd0;
         push_q     <= 1'b0;
         data_q     <= '0;
      end else begin
         infl_vld_q <= |pop_q;
         infl_id_q  <= grant_q;
         push_q     <= infl_vld_q;
         if (infl_vld_q) begin
            data_q <= fifo_data[infl_id_q*DATA_SIZE +: DATA_SIZE];
         end
      end
   end

   assign fifo_pop    = pop_q;
   assign out_push    = push_q;
   assign out_data    = data_q;
   assign grant_id    = grant_q;
   assign sched_error = err_q;
   assign idle        = (state_q == S_IDLE) && (pop_q == 4'b0000) &&
                        !infl_vld_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: array-based source FIFO models, a
// behavioural grant predictor and an in-order scoreboard of pushed words.
module tb_fifo_rr_scheduler;

   localparam int DS = 8;
   localparam int MB = 4;
   localparam int M_IDLE  = 0;
   localparam int M_BURST = 1;
   localparam int M_ERR   = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    fifo_empty, fifo_almost_empty, fifo_error;
   logic [4*DS-1:0] fifo_data;
   logic          out_almost_full, out_pause;
   logic [3:0]    fifo_pop;
   logic          out_push;
   logic [DS-1:0] out_data;
   logic [1:0]    grant_id;
   logic          idle, sched_error;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [DS-1:0] d;
      int            due;
   } exp_t;

   logic [DS-1:0] mem [4][64];
   int            rd [4];
   int            wr [4];
   logic [DS-1:0] pres [4];
   exp_t          exp_q[$];
   int            pop_log[$];
   int            m_mode, m_last, m_run, m_grant;
   logic [3:0]    exp_pop, prev_pop;

   fifo_rr_scheduler #(.DATA_SIZE(DS), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset),
      .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
      .fifo_error(fifo_error), .fifo_data(fifo_data),
      .out_almost_full(out_almost_full), .out_pause(out_pause),
      .fifo_pop(fifo_pop), .out_push(out_push), .out_data(out_data),
      .grant_id(grant_id), .idle(idle), .sched_error(sched_error)
   );

   always #5 clk = ~clk;

   function automatic int cnt(input int i);
      return wr[i] - rd[i];
   endfunction

   task automatic fill(input int i, input int n);
      for (int k = 0; k < n; k++) begin
         if (wr[i] < 64) begin
            mem[i][wr[i]] = DS'($urandom);
            wr[i]++;
         end
      end
   endtask

   // Grant rules in plain terms: words not yet popped decide eligibility.
   task automatic predict(input logic stall, input logic [3:0] err);
      int  j;
      logic found;
      prev_pop = exp_pop;
      exp_pop  = 4'b0000;
      if (|err) begin
         m_mode = M_ERR;
      end else if (m_mode != M_ERR && !stall) begin
         if (m_mode == M_BURST && cnt(m_last) > 0 && m_run < MB) begin
            exp_pop[m_last] = 1'b1;
            m_run++;
         end else begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
               j = (m_last + k) % 4;
               if (!found && cnt(j) > 0) begin
                  found      = 1'b1;
                  exp_pop[j] = 1'b1;
                  m_last     = j;
                  m_grant    = j;
                  m_run      = 1;
                  m_mode     = M_BURST;
               end
            end
            if (!found) m_mode = M_IDLE;
         end
      end else if (m_mode != M_ERR) begin
         prev_pop = prev_pop;
      end
   endtask

   task automatic step(input logic af, input logic ps, input logic [3:0] err);
      logic [3:0] p;
      logic       bad;
      logic       e_idle;
      @(posedge clk);
      #1;
      cyc++;
      p = fifo_pop;
      checks++;
      if (p !== exp_pop) begin
         errors++;
         $display("FAIL pop cyc=%0d got=%b want=%b", cyc, p, exp_pop);
      end
      checks++;
      if ($countones(p) > 1) begin
         errors++;
         $display("FAIL onehot cyc=%0d got=%b want=at most one bit", cyc, p);
      end
      bad = 1'b0;
      for (int i = 0; i < 4; i++) if (p[i] && cnt(i) == 0) bad = 1'b1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL underflow cyc=%0d pop=%b got=empty-pop want=none", cyc, p);
      end
      checks++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         if (out_push !== 1'b1 || out_data !== exp_q[0].d) begin
            errors++;
            $display("FAIL push cyc=%0d got=%b/%h want=1/%h",
                     cyc, out_push, out_data, exp_q[0].d);
         end
         void'(exp_q.pop_front());
      end else if (out_push !== 1'b0) begin
         errors++;
         $display("FAIL push cyc=%0d got=%b want=0", cyc, out_push);
      end
      checks++;
      if (grant_id !== 2'(m_grant)) begin
         errors++;
         $display("FAIL grant_id cyc=%0d got=%0d want=%0d", cyc, grant_id, m_grant);
      end
      checks++;
      if (sched_error !== (m_mode == M_ERR)) begin
         errors++;
         $display("FAIL sched_error cyc=%0d got=%b want=%b",
                  cyc, sched_error, (m_mode == M_ERR));
      end
      e_idle = (m_mode == M_IDLE) && (exp_pop == 4'b0) && (prev_pop == 4'b0);
      checks++;
      if (idle !== e_idle) begin
         errors++;
         $display("FAIL idle cyc=%0d got=%b want=%b", cyc, idle, e_idle);
      end
      // Drive the sources for this cycle, then apply this cycle's pops.
      for (int i = 0; i < 4; i++) begin
         fifo_empty[i]        = (cnt(i) == 0);
         fifo_almost_empty[i] = (cnt(i) <= 1);
         fifo_data[i*DS +: DS] = pres[i];
      end
      out_almost_full = af;
      out_pause       = ps;
      fifo_error      = err;
      for (int i = 0; i < 4; i++) begin
         if (p[i] && cnt(i) > 0) begin
            pres[i] = mem[i][rd[i]];
            rd[i]++;
            exp_q.push_back('{d: pres[i], due: cyc + 2});
            pop_log.push_back(i);
         end
      end
      predict(af | ps, err);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      fifo_empty = 4'hF;
      fifo_almost_empty = 4'hF;
      fifo_error = 4'h0;
      fifo_data = '0;
      out_almost_full = 1'b0;
      out_pause = 1'b0;
      #1;
      checks++;
      if (fifo_pop !== 4'b0 || out_push !== 1'b0) begin
         errors++;
         $display("FAIL rst_strobes got=%b/%b want=0000/0", fifo_pop, out_push);
      end
      checks++;
      if (out_data !== '0) begin
         errors++;
         $display("FAIL rst_data got=%h want=00", out_data);
      end
      checks++;
      if (grant_id !== 2'd0) begin
         errors++;
         $display("FAIL rst_grant got=%0d want=0", grant_id);
      end
      checks++;
      if (sched_error !== 1'b0) begin
         errors++;
         $display("FAIL rst_err got=%b want=0", sched_error);
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         rd[i] = 0;
         wr[i] = 0;
         pres[i] = '0;
      end
      exp_q.delete();
      pop_log.delete();
      m_mode = M_IDLE;
      m_last = 3;
      m_run = 0;
      m_grant = 0;
      exp_pop = 4'b0;
      prev_pop = 4'b0;
      reset = 1'b1;
      checks++;
      if (idle !== 1'b1) begin
         errors++;
         $display("FAIL rst_idle got=%b want=1", idle);
      end
   endtask

   task automatic check_log(input string nm, input int idx, input int want);
      checks++;
      if (pop_log.size() <= idx) begin
         errors++;
         $display("FAIL %s[%0d] got=none want=%0d", nm, idx, want);
      end else if (pop_log[idx] != want) begin
         errors++;
         $display("FAIL %s[%0d] got=%0d want=%0d", nm, idx, pop_log[idx], want);
      end
   endtask

   task automatic test_reset();
      do_reset();
      repeat (3) step(1'b0, 1'b0, 4'h0);
   endtask

   task automatic test_all_full();
      do_reset();
      for (int i = 0; i < 4; i++) fill(i, 8);
      repeat (45) step(1'b0, 1'b0, 4'h0);
      for (int n = 0; n < 32; n++) check_log("order", n, (n / 4) % 4);
      checks++;
      if (exp_q.size() != 0 || idle !== 1'b1) begin
         errors++;
         $display("FAIL drain got=%0d/%b want=0/1", exp_q.size(), idle);
      end
   endtask

   task automatic test_partial();
      do_reset();
      fill(2, 3);
      repeat (8) step(1'b0, 1'b0, 4'h0);
      checks++;
      if (pop_log.size() != 3) begin
         errors++;
         $display("FAIL partial_pops got=%0d want=3", pop_log.size());
      end
      for (int n = 0; n < 3; n++) check_log("partial", n, 2);
      checks++;
      if (idle !== 1'b1) begin
         errors++;
         $display("FAIL partial_idle got=%b want=1", idle);
      end
   endtask

   task automatic test_stall();
      do_reset();
      fill(0, 8);
      fill(1, 8);
      repeat (2) step(1'b0, 1'b0, 4'h0);
      repeat (3) step(1'b1, 1'b0, 4'h0);
      repeat (12) step(1'b0, 1'b0, 4'h0);
      for (int n = 0; n < 4; n++) check_log("stall", n, 0);
      check_log("stall", 4, 1);
   endtask

   task automatic test_wrap();
      do_reset();
      fill(3, 1);
      repeat (6) step(1'b0, 1'b0, 4'h0);
      fill(0, 5);
      fill(3, 5);
      repeat (20) step(1'b0, 1'b0, 4'h0);
      check_log("wrap", 0, 3);
      for (int n = 1; n < 5; n++) check_log("wrap", n, 0);
      for (int n = 5; n < 9; n++) check_log("wrap", n, 3);
      check_log("wrap", 9, 0);
   endtask

   task automatic test_error();
      do_reset();
      fill(1, 8);
      repeat (3) step(1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b0, 4'b0010);
      repeat (6) step(1'b0, 1'b0, 4'h0);
      checks++;
      if (pop_log.size() != 3 || sched_error !== 1'b1) begin
         errors++;
         $display("FAIL error_stop got=%0d/%b want=3/1", pop_log.size(), sched_error);
      end
      do_reset();
      repeat (2) step(1'b0, 1'b0, 4'h0);
   endtask

   task automatic test_reset_midburst();
      do_reset();
      fill(0, 8);
      repeat (3) step(1'b0, 1'b0, 4'h0);
      do_reset();
      repeat (5) step(1'b0, 1'b0, 4'h0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         do_reset();
         for (int i = 0; i < 4; i++) fill(i, $urandom_range(0, 8));
         for (int c = 0; c < 80; c++) begin
            if ($urandom_range(0, 9) == 0) fill($urandom_range(0, 3), $urandom_range(1, 3));
            step($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, 4'h0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_all_full();
      test_partial();
      test_stall();
      test_wrap();
      test_error();
      test_reset_midburst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_rr_scheduler.md
FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, width of one FIFO word.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum consecutive pops granted to one FIFO (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fifo_empty  input  4  empty flag of source FIFO i at bit i.
REQ-006 SHALL have port fifo_almost_empty  input  4  source FIFO i holds at most 1 word.
REQ-007 SHALL have port fifo_error  input  4  error flag of source FIFO i.
REQ-008 SHALL have port fifo_data  input  4*DATA_SIZE  data_out_pop of FIFO i at bits [i*DATA_SIZE +: DATA_SIZE].
REQ-009 SHALL have port out_almost_full  input  1  destination FIFO almost full.
REQ-010 SHALL have port out_pause  input  1  destination pause request.
REQ-011 SHALL have port fifo_pop  output  4  registered, at most one hot, read strobe to source FIFO i.
REQ-012 SHALL have port out_push  output  1  registered write strobe to destination FIFO.
REQ-013 SHALL have port out_data  output  DATA_SIZE  registered word for destination FIFO.
REQ-014 SHALL have port grant_id  output  2  index of the FIFO currently or last granted.
REQ-015 SHALL have port idle  output  1  high when the state is IDLE and no word is in flight.
REQ-016 SHALL have port sched_error  output  1  sticky error indication.

Function
REQ-017 SHALL treat a source FIFO as presenting data during the cycle after the cycle in which its pop is high.
REQ-018 SHALL register the granted word at the end of that data cycle, so out_push/out_data are asserted exactly 2 cycles after the pop cycle (latency 2), in pop order.
REQ-019 SHALL compute stall = out_almost_full | out_pause; the integration SHALL set the destination almost_full margin to at least 2 words.
REQ-020 SHALL compute eligible[i] = ~fifo_empty[i] & ~(fifo_pop[i] & fifo_almost_empty[i]), preventing underflow from stale flags on back-to-back pops.
REQ-021 SHALL implement states IDLE, BURST and ERROR, with a burst counter and a last-grant pointer.
REQ-022 In IDLE with ~stall and any eligible FIFO: SHALL grant the round-robin pick, assert its pop next cycle, set burst_cnt=1 and enter BURST.
REQ-023 In BURST with stall: SHALL drive fifo_pop=0 and hold grant_id and burst_cnt.
REQ-024 In BURST with ~stall, current FIFO eligible and burst_cnt<MAX_BURST: SHALL pop the same FIFO and increment burst_cnt.
REQ-025 In BURST otherwise: SHALL pop the round-robin pick (search from grant_id+1, wrapping 3->0, current FIFO last) and set burst_cnt=1; if none is eligible, SHALL drive pop=0 and enter IDLE.
REQ-026 SHALL update the last-grant pointer only on an actual pop.
REQ-027 On any fifo_error bit sampled high in any state: SHALL enter ERROR, set sched_error=1, and force fifo_pop=0 from the next cycle.
REQ-028 SHALL still deliver words already in flight when entering ERROR; ERROR SHALL exit only by reset.
REQ-029 SHALL never assert more than one fifo_pop bit in a cycle, nor pop a FIFO whose fifo_empty is high.

Reset
REQ-030 While reset=0: SHALL asynchronously force fifo_pop=0, out_push=0, out_data=0, grant_id=0, sched_error=0, burst_cnt=0 and state IDLE.
REQ-031 While reset=0: SHALL preset the last-grant pointer to 3, so the first grant after reset goes to FIFO 0 when it is eligible.
REQ-032 Reset asserted mid-burst SHALL discard in-flight words; idle SHALL read 1 after release.

Verification
REQ-033 All four FIFOs hold 8 words, MAX_BURST=4, no stall -> pop order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; each out_push 2 cycles after its pop; out_data matches.
REQ-034 Only FIFO2 holds 3 words (almost_empty flags driven per REQ-006) -> exactly 3 consecutive pops, then pop=0, IDLE, idle=1 after 2 cycles; no underflow.
REQ-035 out_almost_full raised after the 2nd pop of a FIFO0 burst -> pop=0 from the next cycle; after release, 2 more FIFO0 pops, then FIFO1.
REQ-036 Last grant 3, FIFOs 0 and 3 eligible -> next grant FIFO 0 (wrap); FIFO 3 follows after FIFO 0's burst.
REQ-037 fifo_error[1] pulsed for 1 cycle during a burst -> sched_error=1 next cycle; pops stay 0; 2 in-flight words still pushed; reset low clears everything.
